pwm_block: RTL and testbench

// - Line-synchronous PWM generator for the display/LED path.
// - Contains an 8-bit free-running time-base counter (the global counter).
// - On every hsync rising edge it restarts the counter and latches the duty value.
// - Drives out high for exactly `duty` clock cycles, once per line, while hsync stays high.

---
 rtl/pwm_pkg.sv | 5 +
 rtl/global_counter.sv | 26 ++
 rtl/pwm_block.sv | 61 ++++++
 tb/tb_pwm_block.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the line-synchronous PWM generator.
package pwm_pkg;
  localparam int PWM_W = 8;
  typedef logic [PWM_W-1:0] pwm_word_t;
endpackage

// File: rtl/global_counter.sv
// Free-running wrapping time-base counter with a synchronous clear.
module global_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = clr ? '0 : count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pwm_block.sv
// Line-synchronous PWM: each hsync rise restarts the time base, latches the
// duty value and drives one pulse of `duty` cycles while hsync stays high.
module pwm_block
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             out
);

  logic             hsync_d_q;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             active_q, active_d;
  logic             out_q, out_d;
  logic [WIDTH-1:0] cnt_d;
  logic             line_start;
  logic             wrap;

  assign line_start = hsync & ~hsync_d_q;
  assign wrap       = (count == '1);

  global_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (line_start),
    .count(count)
  );

  // out is computed from the values loaded on this same edge, so the pulse
  // starts on the line-start edge itself and ends when count reaches duty.
  always_comb begin
    cnt_d  = line_start ? '0 : count + WIDTH'(1);
    duty_d = line_start ? data : duty_q;
    if (line_start)         active_d = 1'b1;
    else if (wrap || !hsync) active_d = 1'b0;
    else                    active_d = active_q;
    out_d  = hsync && (cnt_d < duty_d) && active_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_d_q <= 1'b0;
      duty_q    <= '0;
      active_q  <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      hsync_d_q <= hsync;
      duty_q    <= duty_d;
      active_q  <= active_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_block.sv
// Scoreboard bench for pwm_block: each task queues the expected count/out for
// every cycle it drives and compares them once the edge has happened.
module tb_pwm_block;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hsync = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] count;
  logic       out;

  typedef struct packed { logic [7:0] cnt; logic o; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] tb_cnt = '0;

  pwm_block dut (.clk(clk), .rst(rst), .hsync(hsync), .data(data), .count(count), .out(out));

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      hsync = ~hsync;
      sb.push_back('{8'd0, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (count !== e.cnt) $display("FAIL reset_count k=%0d got %0d want %0d", k, count, e.cnt); else passed++;
      total++; if (out !== e.o) $display("FAIL reset_out k=%0d got %b want %b", k, out, e.o); else passed++;
    end
    hsync = 1'b0;
    rst = 1'b1;
    tb_cnt = '0;
  endtask

  // hsync low for one cycle; counter keeps running, no pulse
  task automatic idle_cycle(input string nm);
    hsync = 1'b0;
    sb.push_back('{tb_cnt + 8'd1, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++; if (count !== e.cnt) $display("FAIL %s_idle_count got %0d want %0d", nm, count, e.cnt); else passed++;
    total++; if (out !== e.o) $display("FAIL %s_idle_out got %b want %b", nm, out, e.o); else passed++;
    tb_cnt = e.cnt;
  endtask

  task automatic test_line(input string nm, input logic [7:0] d, input int ncyc);
    data = d;
    hsync = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      sb.push_back('{8'(k), (k < int'(d))});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (count !== e.cnt) $display("FAIL %s_count k=%0d got %0d want %0d", nm, k, count, e.cnt); else passed++;
      total++; if (out !== e.o) $display("FAIL %s_out k=%0d got %b want %b", nm, k, out, e.o); else passed++;
      tb_cnt = e.cnt;
    end
  endtask

  task automatic test_midline_data();
    data = 8'd20;
    hsync = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 5) data = 8'd100;
      sb.push_back('{8'(k), (k < 20)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (count !== e.cnt) $display("FAIL middata_count k=%0d got %0d want %0d", k, count, e.cnt); else passed++;
      total++; if (out !== e.o) $display("FAIL middata_out k=%0d got %b want %b", k, out, e.o); else passed++;
      tb_cnt = e.cnt;
    end
  endtask

  task automatic test_hsync_drop();
    data = 8'd100;
    hsync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 10) hsync = 1'b0;
      sb.push_back('{8'(k), (k < 10)});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (count !== e.cnt) $display("FAIL drop_count k=%0d got %0d want %0d", k, count, e.cnt); else passed++;
      total++; if (out !== e.o) $display("FAIL drop_out k=%0d got %b want %b", k, out, e.o); else passed++;
      tb_cnt = e.cnt;
    end
  endtask

  // one-cycle hsync gap mid-pulse must restart the line, not extend it
  task automatic test_back_to_back();
    test_line("b2b_first", 8'd20, 8);
    idle_cycle("b2b");
    test_line("b2b_second", 8'd20, 25);
  endtask

  task automatic test_async_reset();
    idle_cycle("arst");
    test_line("arst_pre", 8'd50, 10);
    #2 rst = 1'b0;
    sb.push_back('{8'd0, 1'b0});
    #1;
    e = sb.pop_front();
    total++; if (count !== e.cnt) $display("FAIL arst_async_count got %0d want %0d", count, e.cnt); else passed++;
    total++; if (out !== e.o) $display("FAIL arst_async_out got %b want %b", out, e.o); else passed++;
    hsync = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tb_cnt = '0;
    idle_cycle("arst_rel");
    test_line("arst_post", 8'd5, 10);
  endtask

  initial begin
    test_reset();
    test_line("basic", 8'd20, 40);
    idle_cycle("restart");
    test_line("restart", 8'd20, 30);
    idle_cycle("zero");
    test_line("zero", 8'd0, 30);
    idle_cycle("max");
    test_line("max", 8'd255, 300);
    idle_cycle("middata");
    test_midline_data();
    idle_cycle("drop");
    test_hsync_drop();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
